// File: rtl/fp.sv
// Fixed-point word definition shared by the signal-processing blocks.
//   WORD_LENGTH : width of one signed two's-complement sample
//   fpType      : signed sample type
package fp;
    localparam int WORD_LENGTH = 16;
    typedef logic signed [WORD_LENGTH-1:0] fpType;
endpackage

// File: rtl/spike_pkg.sv
// Types shared by the spike encoder and its event FIFO.
//   ADDRESS_WIDTH : width of a spike address on the shared bus
//   spike_event_t : one queued event (address + ON/OFF polarity)
//   enc_state_e   : encoder FSM states
package spike_pkg;
    localparam int ADDRESS_WIDTH = 8;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] address;
        logic                     on_off;
    } spike_event_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } enc_state_e;
endpackage

// File: rtl/spike_event_fifo.sv
// Synchronous FIFO of spike events with a registered read port.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   push, push_data : write one event (caller never pushes into a full FIFO
//                     unless it pops in the same cycle)
//   pop             : request to move one event onto the read port
//   full, empty     : occupancy flags
//   rd_valid        : read port holds a freshly popped event this cycle
//   rd_data         : last popped event (holds when rd_valid is low)
// A push into an empty FIFO while pop is requested bypasses the storage and
// lands on the read port directly, giving one-cycle fall-through.
module spike_event_fifo
    import spike_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  spike_event_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         rd_valid,
    output spike_event_t rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    spike_event_t mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rd_valid_q, rd_valid_d;
    spike_event_t  rd_data_q, rd_data_d;
    logic          wr_en, rd_en, load;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    always_comb begin
        // Bypassed events never touch the storage.
        wr_en      = push && !(empty && pop);
        rd_en      = pop && !empty;
        load       = pop && (!empty || push);
        rd_valid_d = load;
        rd_data_d  = rd_data_q;
        if (load) begin
            rd_data_d = empty ? push_data : mem_q[rd_ptr_q];
        end
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end
endmodule

// File: rtl/on_off_spike_encoder.sv
// Delta-modulation ON/OFF spike encoder.
// Each channel keeps a reference level; a sample that sits at least one
// threshold step above (below) the reference emits an ON (OFF) event and
// moves the reference one step toward it, up to MAX_EVENTS_PER_SAMPLE
// events per sample. Events are queued and popped onto the spike bus on
// arbiter grants.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   sample_valid/ready  : sample handshake; transfer when both are high
//   sample_channel      : channel index of the sample
//   sample_value        : signed sample (fp::fpType)
//   delta               : threshold step, held stable while busy; <= 0 disables events
//   spike_grant         : arbiter allows one pop this cycle
//   spike_valid         : event on the bus this cycle
//   spike_address       : ADDRESS_BASE + channel (mod 256)
//   spike_on_off        : 1 = ON, 0 = OFF
//   fifo_overflow_stall : encoder is holding an event because the FIFO is full
module on_off_spike_encoder
    import spike_pkg::*;
#(
    parameter int NUM_CHANNELS          = 16,
    parameter int ADDRESS_BASE          = 0,
    parameter int MAX_EVENTS_PER_SAMPLE = 4,
    parameter int FIFO_DEPTH            = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     sample_valid,
    output logic                                     sample_ready,
    input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] sample_channel,
    input  logic [fp::WORD_LENGTH-1:0]               sample_value,
    input  logic [fp::WORD_LENGTH-1:0]               delta,
    input  logic                                     spike_grant,
    output logic                                     spike_valid,
    output logic [ADDRESS_WIDTH-1:0]                 spike_address,
    output logic                                     spike_on_off,
    output logic                                     fifo_overflow_stall
);
    localparam int CW   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int WL   = fp::WORD_LENGTH;
    localparam int CNTW = $clog2(MAX_EVENTS_PER_SAMPLE + 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(MAX_EVENTS_PER_SAMPLE);

    enc_state_e     state_q, state_d;
    logic           ready_q, ready_d;
    logic [CW-1:0]  chan_q, chan_d;
    fp::fpType      value_q, value_d;
    fp::fpType      ref_q, ref_d;
    logic [CNTW-1:0] count_q, count_d;
    fp::fpType      refs_q [NUM_CHANNELS];

    logic           wb_en;
    fp::fpType      wb_ref;
    logic           push;
    logic           stall;
    spike_event_t   push_event;
    logic           fifo_full, fifo_empty;
    spike_event_t   rd_event;

    logic signed [WL:0] diff, neg_diff, diff_next, neg_diff_next, delta_x;
    fp::fpType          delta_s, ref_step;
    logic               delta_pos, ev_on, ev_off, more, push_ok;
    logic [CNTW-1:0]    count_inc;

    always_comb begin
        // Differences are taken one bit wider than a sample so they cannot wrap.
        delta_s       = fp::fpType'(delta);
        delta_x       = $signed({delta[WL-1], delta});
        delta_pos     = (delta_s > 0);
        diff          = $signed({value_q[WL-1], value_q}) - $signed({ref_q[WL-1], ref_q});
        neg_diff      = -diff;
        ev_on         = delta_pos && (diff >= delta_x);
        ev_off        = delta_pos && !ev_on && (neg_diff >= delta_x);
        // The reference only moves toward an in-range sample, so this cannot overflow.
        ref_step      = ev_on ? ref_q + delta_s : ref_q - delta_s;
        diff_next     = $signed({value_q[WL-1], value_q}) - $signed({ref_step[WL-1], ref_step});
        neg_diff_next = -diff_next;
        // Look one step ahead so the last event of a sample also returns to IDLE.
        more          = delta_pos && ((diff_next >= delta_x) || (neg_diff_next >= delta_x));
        count_inc     = count_q + 1'b1;
        // A full FIFO still accepts the push when a pop frees a slot this cycle.
        push_ok       = !fifo_full || spike_grant;

        state_d    = state_q;
        chan_d     = chan_q;
        value_d    = value_q;
        ref_d      = ref_q;
        count_d    = count_q;
        wb_en      = 1'b0;
        wb_ref     = ref_q;
        push       = 1'b0;
        stall      = 1'b0;
        push_event.address = 8'(ADDRESS_BASE) + 8'(chan_q);
        push_event.on_off  = ev_on;

        case (state_q)
            ST_IDLE: begin
                if (sample_valid && ready_q) begin
                    chan_d  = sample_channel;
                    value_d = fp::fpType'(sample_value);
                    ref_d   = refs_q[sample_channel];
                    count_d = '0;
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (ev_on || ev_off) begin
                    if (push_ok) begin
                        push    = 1'b1;
                        ref_d   = ref_step;
                        count_d = count_inc;
                        if ((count_inc == MAX_CNT) || !more) begin
                            wb_en   = 1'b1;
                            wb_ref  = ref_step;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stall = 1'b1;
                    end
                end else begin
                    wb_en   = 1'b1;
                    wb_ref  = ref_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            chan_q  <= '0;
            value_q <= '0;
            ref_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            chan_q  <= chan_d;
            value_q <= value_d;
            ref_q   <= ref_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                refs_q[i] <= '0;
            end
        end else if (wb_en) begin
            refs_q[chan_q] <= wb_ref;
        end
    end

    spike_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_data(push_event),
        .pop      (spike_grant),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .rd_valid (spike_valid),
        .rd_data  (rd_event)
    );

    assign sample_ready        = ready_q;
    assign spike_address       = rd_event.address;
    assign spike_on_off        = rd_event.on_off;
    assign fifo_overflow_stall = stall;
endmodule

// File: tb/tb_on_off_spike_encoder.sv
module tb_on_off_spike_encoder;
  localparam int NCH = 16;
  localparam int MAXEV = 4;
  localparam int ABASE = 0;

  logic        clk;
  logic        reset;
  logic        sample_valid;
  logic        sample_ready;
  logic [3:0]  sample_channel;
  logic [15:0] sample_value;
  logic [15:0] delta;
  logic        spike_grant;
  logic        spike_valid;
  logic [7:0]  spike_address;
  logic        spike_on_off;
  logic        fifo_overflow_stall;

  int n_vec = 0;
  int n_err = 0;
  logic [8:0] exp_q[$];
  int model_ref[NCH];
  logic grant_cmd = 1'b0;
  logic grant_rand = 1'b0;

  on_off_spike_encoder #(
    .NUM_CHANNELS(NCH), .ADDRESS_BASE(ABASE),
    .MAX_EVENTS_PER_SAMPLE(MAXEV), .FIFO_DEPTH(8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_channel(sample_channel), .sample_value(sample_value), .delta(delta),
    .spike_grant(spike_grant), .spike_valid(spike_valid),
    .spike_address(spike_address), .spike_on_off(spike_on_off),
    .fifo_overflow_stall(fifo_overflow_stall)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // grant driver
  initial begin
    spike_grant = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      spike_grant = grant_rand ? 1'($urandom_range(0, 1)) : grant_cmd;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // reference model: step the channel reference toward the sample
  task automatic model_apply(input int ch, input logic [15:0] val, input logic [15:0] dl);
    int r, v, d;
    r = model_ref[ch];
    v = int'($signed(val));
    d = int'($signed(dl));
    for (int k = 0; k < MAXEV; k++) begin
      if (d > 0 && v - r >= d) begin
        exp_q.push_back({8'(ABASE + ch), 1'b1});
        r = r + d;
      end else if (d > 0 && r - v >= d) begin
        exp_q.push_back({8'(ABASE + ch), 1'b0});
        r = r - d;
      end else begin
        break;
      end
    end
    model_ref[ch] = r;
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < NCH; i++) model_ref[i] = 0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && spike_valid) begin
      if (exp_q.size() == 0) begin
        chk("extra_event", {23'b0, spike_address, spike_on_off}, 32'h1ff);
      end else begin
        chk("event", {23'b0, spike_address, spike_on_off}, {23'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) chk("ready_timeout", {31'b0, sample_ready}, 32'd1);
  endtask

  // call at a negedge with sample_ready high; returns #1 after the accepting edge
  task automatic accept(input int ch, input logic [15:0] val, input logic [15:0] dl);
    sample_channel = 4'(ch);
    sample_value   = val;
    delta          = dl;
    sample_valid   = 1'b1;
    @(posedge clk);
    model_apply(ch, val, dl);
    #1 sample_valid = 1'b0;
  endtask

  task automatic send(input int ch, input logic [15:0] val, input logic [15:0] dl);
    wait_ready();
    accept(ch, val, dl);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || !sample_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(tag, exp_q.size(), 32'd0);
  endtask

  task automatic chk_ref(input string tag, input int ch);
    chk(tag, {16'h0, u_dut.refs_q[ch]}, {16'h0, model_ref[ch][15:0]});
  endtask

  initial begin
    int ch;
    logic [15:0] val, dl;
    model_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    sample_channel = '0;
    sample_value = '0;
    delta = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, sample_ready}, 32'd0);
    chk("rst_valid", {31'b0, spike_valid}, 32'd0);
    chk("rst_addr", {24'b0, spike_address}, 32'd0);
    chk("rst_onoff", {31'b0, spike_on_off}, 32'd0);
    chk("rst_stall", {31'b0, fifo_overflow_stall}, 32'd0);
    reset = 1'b0;
    grant_cmd = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_rst", {31'b0, sample_ready}, 32'd1);

    // two ON events with exact timing
    wait_ready();
    accept(3, 16'h0250, 16'h0100);
    chk("t1_ready", {31'b0, sample_ready}, 32'd0);
    chk("t1_valid", {31'b0, spike_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t2_valid", {31'b0, spike_valid}, 32'd1);
    chk("t2_addr", {24'b0, spike_address}, 32'd3);
    chk("t2_onoff", {31'b0, spike_on_off}, 32'd1);
    @(posedge clk); #1;
    chk("t3_valid", {31'b0, spike_valid}, 32'd1);
    chk("t3_ready", {31'b0, sample_ready}, 32'd1);
    drain("drain_two_on");
    chk_ref("ref3_a", 3);

    // one OFF event, residual carried
    send(3, 16'h0050, 16'h0100);
    drain("drain_off");
    chk_ref("ref3_b", 3);

    // event cap
    send(0, 16'h0A00, 16'h0100);
    drain("drain_cap1");
    chk_ref("ref0_a", 0);
    send(0, 16'h0A00, 16'h0100);
    drain("drain_cap2");
    chk_ref("ref0_b", 0);

    // backpressure
    grant_cmd = 1'b0;
    send(5, 16'h0A00, 16'h0100);
    send(6, 16'h0A00, 16'h0100);
    send(7, 16'h0A00, 16'h0100);
    repeat (8) @(negedge clk);
    chk("bp_stall", {31'b0, fifo_overflow_stall}, 32'd1);
    chk("bp_ready", {31'b0, sample_ready}, 32'd0);
    chk("bp_full", {31'b0, u_dut.fifo_full}, 32'd1);
    chk("bp_valid", {31'b0, spike_valid}, 32'd0);
    grant_cmd = 1'b1;
    drain("drain_bp");
    chk_ref("ref7", 7);

    // delta zero / negative extreme
    send(3, 16'h7FFF, 16'h0000);
    drain("drain_d0");
    chk_ref("ref3_d0", 3);
    send(9, 16'h8000, 16'h4000);
    drain("drain_negx");
    chk_ref("ref9", 9);

    // reset mid-operation
    grant_cmd = 1'b0;
    send(1, 16'h0A00, 16'h0100);
    repeat (6) @(negedge clk);
    grant_cmd = 1'b1;
    @(posedge clk); #2;
    chk("pre_rst_valid", {31'b0, spike_valid}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_valid", {31'b0, spike_valid}, 32'd0);
    chk("mid_rst_empty", {31'b0, u_dut.fifo_empty}, 32'd1);
    chk_ref("mid_rst_ref1", 1);
    chk("mid_rst_ready", {31'b0, sample_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    send(3, 16'h0100, 16'h0100);
    drain("drain_post_rst");
    chk_ref("ref3_post", 3);

    // randomized samples with random grants
    grant_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ch  = $urandom_range(0, NCH - 1);
      val = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 7))
        0:       dl = 16'h0000;
        1:       dl = 16'h8000 | 16'($urandom_range(0, 32767));
        default: dl = 16'($urandom_range(1, 16'h3000));
      endcase
      send(ch, val, dl);
    end
    grant_rand = 1'b0;
    grant_cmd = 1'b1;
    drain("drain_random");
    for (int c = 0; c < NCH; c++) chk_ref("ref_random", c);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
